fifo_wr_arbiter: RTL and testbench

//  Shares one sync FIFO write port between NREQ producers using round-robin arbitration.

---
 rtl/fifo_arb_pkg.sv | 25 ++
 rtl/rr_pick.sv | 18 +
 rtl/fifo_wr_arbiter.sv | 133 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and the cyclic round-robin search used by the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Upper bound on requesters handled by rr_next.
  localparam int MAX_NREQ = 32;

  // First set bit of valid strictly after last, wrapping; last itself is
  // checked only after every other index has been passed over.
  function automatic int rr_next(input logic [MAX_NREQ-1:0] valid,
                                 input int last,
                                 input int n);
    int idx;
    rr_next = last;
    for (int k = n; k >= 1; k--) begin
      idx = (last + k) % n;
      if (valid[idx[4:0]]) rr_next = idx;
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: picks the next valid index after last.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   idx,
  output logic            any
);
  import fifo_arb_pkg::*;

  always_comb begin
    idx = IW'(rr_next(MAX_NREQ'(valid), int'(last), NREQ));
    any = |valid;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync FIFO write port between NREQ valid/ready producers.
// FIFO_ARB_BURST_EN: owner keeps the grant for up to MAX_BURST beats; otherwise one beat per grant.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DWIDTH    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DWIDTH-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [DWIDTH-1:0]        fifo_din,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     grant_vld
);
  import fifo_arb_pkg::*;

  localparam int IW = $clog2(NREQ);

  generate
    if (NREQ < 2 || NREQ > MAX_NREQ || DWIDTH < 1 || MAX_BURST < 1) begin : g_bad_cfg
      $error("fifo_wr_arbiter: unsupported NREQ/DWIDTH/MAX_BURST");
    end
  endgenerate

  arb_state_t    state, state_nxt;
  logic [IW-1:0] grant_id_nxt;
  logic [IW-1:0] last_winner, last_winner_nxt;
  logic [IW-1:0] pick_last, pick_idx;
  logic          pick_any;
  logic          owner_vld;
  logic          xfer;
  logic          limit;
  logic          release_g;

  assign owner_vld = req_valid[grant_id];
  assign xfer      = (state == GRANT) && owner_vld && !fifo_full;
  assign grant_vld = (state == GRANT);

`ifdef FIFO_ARB_BURST_EN
  localparam int BW = $clog2(MAX_BURST + 1);

  logic [BW-1:0] beat_cnt, beat_cnt_nxt;

  // Limit hits on the last beat of a burst; release clears the count, so it never wraps.
  assign limit = (beat_cnt == BW'(MAX_BURST - 1));

  always_comb begin
    beat_cnt_nxt = beat_cnt;
    if (release_g)
      beat_cnt_nxt = '0;
    else if (xfer)
      beat_cnt_nxt = beat_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      beat_cnt <= '0;
    else
      beat_cnt <= beat_cnt_nxt;
  end
`else
  assign limit = 1'b1;
`endif

  // A full FIFO blocks xfer, so the grant is held rather than released on the limit.
  assign release_g = (state == GRANT) && ((xfer && limit) || !owner_vld);

  // On release the search starts after the outgoing owner, which is also the new last_winner.
  assign pick_last = (state == GRANT) ? grant_id : last_winner;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .valid (req_valid),
    .last  (pick_last),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    state_nxt       = state;
    grant_id_nxt    = grant_id;
    last_winner_nxt = last_winner;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt    = GRANT;
          grant_id_nxt = pick_idx;
        end
      end
      GRANT: begin
        if (release_g) begin
          last_winner_nxt = grant_id;
          if (pick_any)
            grant_id_nxt = pick_idx;
          else
            state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      grant_id    <= '0;
      last_winner <= IW'(NREQ - 1);
    end else begin
      state       <= state_nxt;
      grant_id    <= grant_id_nxt;
      last_winner <= last_winner_nxt;
    end
  end

  always_comb begin
    req_ready = '0;
    fifo_din  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (xfer && (grant_id == IW'(i))) begin
        req_ready[i] = 1'b1;
        fifo_din     = req_data[i*DWIDTH +: DWIDTH];
      end
    end
  end

  assign fifo_wr_en = xfer;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, directed corner sequences, randomized run vs. a reference model.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DW    = 16;
  localparam int MB    = 4;
  localparam int DEPTH = 8;
`ifdef FIFO_ARB_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rstn;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]  req_ready;
  logic             fifo_wr_en;
  logic [DW-1:0]    fifo_din;
  logic [1:0]       grant_id;
  logic             grant_vld;

  logic             fifo_full_q = 1'b0;
  logic             full_force  = 1'b0;
  logic             full_sig;
  logic             fifo_rd     = 1'b0;
  logic             fifo_clr    = 1'b0;
  logic [DW-1:0]    fifo_q[$];
  logic [DW-1:0]    rd_log[$];
  int               overflow    = 0;

  int n_cmp = 0;
  int n_bad = 0;

  assign full_sig = fifo_full_q | full_force;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NREQ(NREQ), .DWIDTH(DW), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (full_sig),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .grant_id   (grant_id),
    .grant_vld  (grant_vld)
  );

  // Depth-8 sync FIFO write/read side; a write while full is counted as overflow.
  always @(posedge clk) begin
    if (fifo_clr) begin
      fifo_q.delete();
    end else begin
      if (fifo_rd && fifo_q.size() > 0) rd_log.push_back(fifo_q.pop_front());
      if (fifo_wr_en === 1'b1) begin
        if (full_sig) overflow <= overflow + 1;
        else fifo_q.push_back(fifo_din);
      end
    end
    fifo_full_q <= (fifo_q.size() >= DEPTH);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fifo_rd   = 1'b0;
    full_force = 1'b0;
    fifo_clr  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rstn     = 1'b1;
    fifo_clr = 1'b0;
    rd_log.delete();
    next_cyc();
  endtask

  function automatic int m_pick(input logic [3:0] v, input int last);
    logic [1:0] j;
    for (int k = 1; k <= NREQ; k++) begin
      j = 2'((last + k) % NREQ);
      if (v[j]) return int'(j);
    end
    return -1;
  endfunction

  typedef struct {
    logic [3:0]  v;
    logic        f;
    logic        wr;
    logic [15:0] din;
    logic [3:0]  rdy;
    logic        gv;
    logic [1:0]  gid;
  } vec_t;

  initial begin
    vec_t        tbl[14];
    int          w;
    int          m_owner, m_last, m_beats, e;
    logic [1:0]  ow;
    logic        x, rel, ew, eg;
    logic [15:0] ed;
    logic [3:0]  er, prev_rdy;
    int          rd_pct;

    tbl[0]  = '{4'b0000, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 2'd0};
    tbl[1]  = '{4'b0001, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 2'd0};
    tbl[2]  = '{4'b0001, 1'b0, 1'b1, 16'h1111, 4'b0001, 1'b1, 2'd0};
    tbl[3]  = '{4'b0001, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b1, 2'd0};
    tbl[4]  = '{4'b0101, 1'b0, 1'b1, 16'h1111, 4'b0001, 1'b1, 2'd0};
    tbl[5]  = '{4'b0101, 1'b0, 1'b1, 16'h3333, 4'b0100, 1'b1, 2'd2};
    tbl[6]  = '{4'b0000, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b1, 2'd0};
    tbl[7]  = '{4'b1000, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 2'd0};
    tbl[8]  = '{4'b1010, 1'b0, 1'b1, 16'h4444, 4'b1000, 1'b1, 2'd3};
    tbl[9]  = '{4'b0010, 1'b0, 1'b1, 16'h2222, 4'b0010, 1'b1, 2'd1};
    tbl[10] = '{4'b0110, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b1, 2'd1};
    tbl[11] = '{4'b0110, 1'b0, 1'b1, 16'h2222, 4'b0010, 1'b1, 2'd1};
    tbl[12] = '{4'b0000, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b1, 2'd2};
    tbl[13] = '{4'b0000, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 2'd0};

    // Reset state: outputs stay quiet even with every requester valid.
    rstn      = 1'b0;
    req_valid = 4'b1111;
    req_data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    #12;
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_din", 32'(fifo_din), 32'd0);
    chk("rst_gvld", 32'(grant_vld), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);

    // Test 1: single requester, three beats, read back in order.
    do_reset();
    req_valid = 4'b0001;
    req_data[15:0] = 16'hA000;
    @(negedge clk);
    chk("t1_idle_wr", 32'(fifo_wr_en), 32'd0);
    chk("t1_idle_gvld", 32'(grant_vld), 32'd0);
    for (int k = 0; k < 3; k++) begin
      next_cyc();
      req_data[15:0] = 16'hA000 + 16'(k);
      @(negedge clk);
      chk("t1_wr", 32'(fifo_wr_en), 32'd1);
      chk("t1_din", 32'(fifo_din), 32'hA000 + 32'(k));
      chk("t1_rdy", 32'(req_ready), 32'b0001);
      chk("t1_gid", 32'(grant_id), 32'd0);
    end
    next_cyc();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("t1_drop_wr", 32'(fifo_wr_en), 32'd0);
    next_cyc();
    @(negedge clk);
    chk("t1_back_idle", 32'(grant_vld), 32'd0);
    fifo_rd = 1'b1;
    repeat (3) next_cyc();
    fifo_rd = 1'b0;
    chk("t1_rd_count", 32'(rd_log.size()), 32'd3);
    for (int k = 0; k < 3; k++) chk("t1_rd_data", 32'(rd_log[k]), 32'hA000 + 32'(k));

`ifndef FIFO_ARB_BURST_EN
    // Per-beat round-robin vectors, one table row per cycle.
    do_reset();
    req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    for (int s = 0; s < 14; s++) begin
      req_valid  = tbl[s].v;
      full_force = tbl[s].f;
      @(negedge clk);
      chk("tbl_wr", 32'(fifo_wr_en), 32'(tbl[s].wr));
      chk("tbl_din", 32'(fifo_din), 32'(tbl[s].din));
      chk("tbl_rdy", 32'(req_ready), 32'(tbl[s].rdy));
      chk("tbl_gvld", 32'(grant_vld), 32'(tbl[s].gv));
      if (tbl[s].gv) chk("tbl_gid", 32'(grant_id), 32'(tbl[s].gid));
      next_cyc();
    end
    full_force = 1'b0;
`endif

    // Tests 2/3: all four valid, back-to-back writes across handovers.
    do_reset();
    req_data  = {16'h6003, 16'h6002, 16'h6001, 16'h6000};
    req_valid = 4'b1111;
    fifo_rd   = 1'b1;
    @(negedge clk);
    chk("t2_idle", 32'(grant_vld), 32'd0);
    for (int k = 0; k < 8; k++) begin
      next_cyc();
      e = BURST ? (k / MB) : (k % NREQ);
      @(negedge clk);
      chk("t2_wr", 32'(fifo_wr_en), 32'd1);
      chk("t2_gid", 32'(grant_id), 32'(e));
      chk("t2_din", 32'(fifo_din), 32'h6000 + 32'(e));
    end
    req_valid = '0;
    fifo_rd   = 1'b0;

    // Test 4: req2 fills the FIFO, is held while full, then one read frees one write.
    do_reset();
    req_valid = 4'b0100;
    req_data[47:32] = 16'hC000;
    w = 0;
    for (int c = 0; c < 40 && w < DEPTH; c++) begin
      @(negedge clk);
      if (req_ready[2]) w++;
      next_cyc();
      req_data[47:32] = 16'hC000 + 16'(w);
    end
    chk("t4_fill", 32'(w), 32'(DEPTH));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t4_full_wr", 32'(fifo_wr_en), 32'd0);
      chk("t4_full_rdy", 32'(req_ready), 32'd0);
      chk("t4_full_gid", 32'(grant_id), 32'd2);
      next_cyc();
    end
    fifo_rd = 1'b1;
    next_cyc();
    fifo_rd = 1'b0;
    @(negedge clk);
    chk("t4_one_wr", 32'(fifo_wr_en), 32'd1);
    chk("t4_one_din", 32'(fifo_din), 32'hC008);
    chk("t4_one_rdy", 32'(req_ready), 32'b0100);
    next_cyc();
    req_data[47:32] = 16'hC009;
    @(negedge clk);
    chk("t4_refull_wr", 32'(fifo_wr_en), 32'd0);
    req_valid = '0;
    fifo_rd   = 1'b1;
    repeat (10) next_cyc();
    fifo_rd = 1'b0;
    chk("t4_rd_count", 32'(rd_log.size()), 32'd9);
    for (int k = 0; k < 9; k++) chk("t4_rd_data", 32'(rd_log[k]), 32'hC000 + 32'(k));

    // Test 5: owner req1 withdraws while req3 waits.
    do_reset();
    req_data  = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
    req_valid = 4'b0010;
    next_cyc();
    @(negedge clk);
    chk("t5_own1_din", 32'(fifo_din), 32'hD001);
    next_cyc();
    @(negedge clk);
    chk("t5_own1_gid", 32'(grant_id), 32'd1);
    next_cyc();
    req_valid = 4'b1000;
    @(negedge clk);
    chk("t5_drop_wr", 32'(fifo_wr_en), 32'd0);
    chk("t5_drop_gid", 32'(grant_id), 32'd1);
    next_cyc();
    @(negedge clk);
    chk("t5_next_gid", 32'(grant_id), 32'd3);
    chk("t5_next_din", 32'(fifo_din), 32'hD003);
    chk("t5_next_rdy", 32'(req_ready), 32'b1000);
    req_valid = '0;

    // Test 6: asynchronous reset mid-burst, then req0 wins first.
    do_reset();
    req_data  = {16'h5003, 16'h5002, 16'h5001, 16'h5000};
    req_valid = 4'b1111;
    next_cyc();
    next_cyc();
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_rst_wr", 32'(fifo_wr_en), 32'd0);
    chk("t6_rst_rdy", 32'(req_ready), 32'd0);
    chk("t6_rst_din", 32'(fifo_din), 32'd0);
    chk("t6_rst_gvld", 32'(grant_vld), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    chk("t6_idle_gvld", 32'(grant_vld), 32'd0);
    next_cyc();
    @(negedge clk);
    chk("t6_first_gid", 32'(grant_id), 32'd0);
    chk("t6_first_din", 32'(fifo_din), 32'h5000);
    req_valid = '0;

    // Randomized run against the reference model.
    do_reset();
    m_owner  = -1;
    m_last   = NREQ - 1;
    m_beats  = 0;
    prev_rdy = '0;
    for (int c = 0; c < 1200; c++) begin
      rd_pct = (c < 600) ? 30 : 85;
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && prev_rdy[i]) begin
          req_valid[i] = ($urandom % 4) != 0;
          req_data[i*DW +: DW] = 16'($urandom);
        end else if (req_valid[i]) begin
          if ($urandom % 16 == 0) req_valid[i] = 1'b0;
        end else if ($urandom % 3 == 0) begin
          req_valid[i] = 1'b1;
          req_data[i*DW +: DW] = 16'($urandom);
        end
      end
      fifo_rd = ($urandom % 100) < rd_pct;
      @(negedge clk);
      ew = 1'b0; ed = '0; er = '0; eg = (m_owner >= 0); x = 1'b0;
      ow = 2'(m_owner);
      if (eg) begin
        x = req_valid[ow] && !full_sig;
        if (x) begin
          ew = 1'b1;
          ed = req_data[int'(ow)*DW +: DW];
          er[ow] = 1'b1;
        end
      end
      chk("rnd_wr", 32'(fifo_wr_en), 32'(ew));
      chk("rnd_din", 32'(fifo_din), 32'(ed));
      chk("rnd_rdy", 32'(req_ready), 32'(er));
      chk("rnd_gvld", 32'(grant_vld), 32'(eg));
      if (eg) chk("rnd_gid", 32'(grant_id), 32'(ow));
      if (!eg) begin
        m_owner = m_pick(req_valid, m_last);
      end else begin
        if (x) m_beats++;
        rel = (x && (!BURST || m_beats == MB)) || !req_valid[ow];
        if (rel) begin
          m_last  = m_owner;
          m_beats = 0;
          m_owner = m_pick(req_valid, m_last);
        end
      end
      prev_rdy = er;
      next_cyc();
    end
    req_valid = '0;
    fifo_rd   = 1'b0;
    next_cyc();
    chk("no_overflow", 32'(overflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
